// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential integer divider.
// Widths up to MAX_W are supported by the negate helper.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   localparam int MAX_W = 64;

   // Two's-complement negate; callers zero-extend to MAX_W and truncate back.
   function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] v);
      return ~v + MAX_W'(1);
   endfunction

endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring radix-2 iteration on {rem, qbits}.
module div_nr_step #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH:0]   rem,
   input  logic        [WIDTH-1:0] qbits,
   input  logic        [WIDTH-1:0] dvs,
   output logic signed [WIDTH:0]   rem_next,
   output logic        [WIDTH-1:0] qbits_next
);

   logic signed [WIDTH:0] shifted;
   logic signed [WIDTH:0] dvs_ext;

   // Dropping rem[WIDTH] in the shift is safe: the result always lands in [-d, d).
   assign shifted    = {rem[WIDTH-1:0], qbits[WIDTH-1]};
   assign dvs_ext    = {1'b0, dvs};
   assign rem_next   = rem[WIDTH] ? shifted + dvs_ext : shifted - dvs_ext;
   assign qbits_next = {qbits[WIDTH-2:0], ~rem_next[WIDTH]};

endmodule

// File: rtl/div_seq.sv
// Iterative signed/unsigned divider: fixed WIDTH+1 edge latency, truncating
// toward zero, with explicit divide-by-zero reporting.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sign_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t state, state_next;
   logic [CNT_W-1:0] count;

   logic signed [WIDTH:0]   rem;
   logic signed [WIDTH:0]   rem_next;
   logic signed [WIDTH:0]   rem_fix;
   logic        [WIDTH-1:0] qbits, qbits_next;
   logic        [WIDTH-1:0] dvs_mag, dvd_raw;
   logic                    q_neg, r_neg, zero_div;

   logic                    dvd_neg, dvs_neg;
   logic        [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
   logic        [WIDTH-1:0] q_fix, r_fix;

   // Operand magnitudes; |MIN| fits in WIDTH unsigned bits.
   assign dvd_neg    = (sign_mode == MODE_SIGNED) && dividend[WIDTH-1];
   assign dvs_neg    = (sign_mode == MODE_SIGNED) && divisor[WIDTH-1];
   assign dvd_mag_in = dvd_neg ? WIDTH'(negate(MAX_W'(dividend))) : dividend;
   assign dvs_mag_in = dvs_neg ? WIDTH'(negate(MAX_W'(divisor)))  : divisor;

   div_nr_step #(.WIDTH(WIDTH)) u_step (
      .rem        (rem),
      .qbits      (qbits),
      .dvs        (dvs_mag),
      .rem_next   (rem_next),
      .qbits_next (qbits_next)
   );

   // Fix-up: restore a negative remainder, then apply result signs.
   // Signed MIN / -1 needs no special path: |MIN| / 1 with a positive sign yields MIN, 0.
   assign rem_fix = rem[WIDTH] ? rem + $signed({1'b0, dvs_mag}) : rem;
   assign q_fix   = zero_div ? '1 :
                    (q_neg ? WIDTH'(negate(MAX_W'(qbits))) : qbits);
   assign r_fix   = zero_div ? dvd_raw :
                    (r_neg ? WIDTH'(negate(MAX_W'(rem_fix[WIDTH-1:0]))) : rem_fix[WIDTH-1:0]);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (count == CNT_W'(WIDTH-1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         q        <= '0;
         r        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               busy  <= 1'b1;
               count <= '0;
            end
            CALC: count <= count + CNT_W'(1);
            FIX: begin
               busy     <= 1'b0;
               done     <= 1'b1;
               q        <= q_fix;
               r        <= r_fix;
               div_zero <= zero_div;
            end
            default: ;
         endcase
      end
   end

   // Datapath registers carry no reset; the FSM never consumes them before a capture.
   always_ff @(posedge clock) begin
      if (state == IDLE && start) begin
         rem      <= '0;
         qbits    <= dvd_mag_in;
         dvs_mag  <= dvs_mag_in;
         dvd_raw  <= dividend;
         q_neg    <= dvd_neg ^ dvs_neg;
         r_neg    <= dvd_neg;
         zero_div <= (divisor == '0);
      end else if (state == CALC) begin
         rem   <= rem_next;
         qbits <= qbits_next;
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (WIDTH=32): directed corner cases plus
// random operations against an arithmetic reference model.
module tb_div_seq;

   localparam int W = 32;
   localparam int LAT = W + 1;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         sign_mode = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] q, r;

   int total = 0;
   int bad = 0;

   div_seq #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .sign_mode (sign_mode),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .q         (q),
      .r         (r)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic         sm;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         ez;
   } vec_t;

   // Reference: plain integer division, truncating toward zero.
   function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] eq, output logic [W-1:0] er, output logic ez);
      longint sa, sb, qq, rr;
      if (b == 0) begin
         eq = '1; er = a; ez = 1'b1;
      end else if (!sm) begin
         eq = a / b; er = a % b; ez = 1'b0;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         qq = sa / sb;
         rr = sa % sb;
         eq = qq[W-1:0]; er = rr[W-1:0]; ez = 1'b0;
      end
   endfunction

   task automatic step();
      @(posedge clock); #1;
   endtask

   // Launch one op, scramble the inputs right after the accepting edge, wait for done.
   task automatic do_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] oq, output logic [W-1:0] orr, output logic oz,
                        output int lat);
      sign_mode = sm; dividend = a; divisor = b; start = 1'b1;
      step();
      start = 1'b0; sign_mode = ~sm; dividend = $urandom; divisor = $urandom;
      lat = 0;
      while (!done && lat < 100) begin
         step();
         lat++;
      end
      oq = q; orr = r; oz = div_zero;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      total++;
      if ({busy, done, div_zero, q, r} !== {3'b000, 32'h0, 32'h0}) begin
         bad++;
         $display("FAIL reset got busy=%b done=%b dz=%b q=%h r=%h want all zero", busy, done, div_zero, q, r);
      end
   endtask

   task automatic test_directed();
      vec_t vecs[9] = '{
         '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0},
         '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0},
         '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0},
         '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0},
         '{1'b0, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  32'd1,         1'b0},
         '{1'b1, 32'hFFFFFFFF,  32'd2,         32'd0,         32'hFFFFFFFF,  1'b0},
         '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1},
         '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1},
         '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0}
      };
      logic [W-1:0] oq, orr;
      logic oz;
      int lat;
      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].sm, vecs[i].a, vecs[i].b, oq, orr, oz, lat);
         total++;
         if ({oq, orr, oz} !== {vecs[i].eq, vecs[i].er, vecs[i].ez}) begin
            bad++;
            $display("FAIL directed[%0d] got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     i, oq, orr, oz, vecs[i].eq, vecs[i].er, vecs[i].ez);
         end
         total++;
         if (lat !== LAT) begin
            bad++;
            $display("FAIL latency[%0d] got %0d want %0d", i, lat, LAT);
         end
         step();
         total++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse[%0d] got done=%b busy=%b want 0 0", i, done, busy);
         end
      end
      // Results must hold while idle.
      repeat (5) step();
      total++;
      if ({q, r, div_zero} !== {vecs[8].eq, vecs[8].er, vecs[8].ez}) begin
         bad++;
         $display("FAIL hold got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                  q, r, div_zero, vecs[8].eq, vecs[8].er, vecs[8].ez);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, oq, orr, eq, er;
      logic sm, oz, ez;
      int lat;
      for (int i = 0; i < 40; i++) begin
         sm = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 4))
            0: b = W'($urandom_range(0, 3));
            1: b = 32'hFFFFFFFF;
            2: b = W'($urandom_range(1, 1000));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         model(sm, a, b, eq, er, ez);
         do_op(sm, a, b, oq, orr, oz, lat);
         total++;
         if ({oq, orr, oz, lat} !== {eq, er, ez, LAT}) begin
            bad++;
            $display("FAIL random[%0d] sm=%b a=%h b=%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                     i, sm, a, b, oq, orr, oz, lat, eq, er, ez, LAT);
         end
      end
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] eq, er;
      logic ez;
      int n;
      model(1'b0, 32'd1000, 32'd33, eq, er, ez);
      sign_mode = 1'b0; dividend = 32'd1000; divisor = 32'd33; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      repeat (10) begin step(); n++; end
      sign_mode = 1'b1; dividend = 32'd77; divisor = 32'd0; start = 1'b1;
      step(); n++;
      start = 1'b0;
      while (!done && n < 100) begin step(); n++; end
      total++;
      if ({q, r, div_zero, n} !== {eq, er, ez, LAT}) begin
         bad++;
         $display("FAIL start_ignored got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                  q, r, div_zero, n, eq, er, ez, LAT);
      end
      step();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL start_not_queued got busy=%b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] oq, orr, eq, er;
      logic oz, ez;
      int lat;
      do_op(1'b0, 32'd999, 32'd10, oq, orr, oz, lat);
      // Still in the done cycle: the next start must be accepted at once.
      model(1'b1, 32'hFFFFFC18, 32'd7, eq, er, ez);
      do_op(1'b1, 32'hFFFFFC18, 32'd7, oq, orr, oz, lat);
      total++;
      if ({oq, orr, oz, lat} !== {eq, er, ez, LAT}) begin
         bad++;
         $display("FAIL back_to_back got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                  oq, orr, oz, lat, eq, er, ez, LAT);
      end
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] oq, orr, eq, er;
      logic oz, ez;
      int lat, seen;
      sign_mode = 1'b0; dividend = 32'd12345; divisor = 32'd11; start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      reset = 1'b1;
      #1;
      total++;
      if ({busy, done, q, r} !== {2'b00, 32'h0, 32'h0}) begin
         bad++;
         $display("FAIL reset_abort got busy=%b done=%b q=%h r=%h want 0 0 0 0", busy, done, q, r);
      end
      step();
      reset = 1'b0;
      seen = 0;
      repeat (40) begin step(); if (done) seen++; end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL abort_no_done got %0d done pulses want 0", seen);
      end
      model(1'b1, 32'hFFFFFF00, 32'd3, eq, er, ez);
      do_op(1'b1, 32'hFFFFFF00, 32'd3, oq, orr, oz, lat);
      total++;
      if ({oq, orr, oz, lat} !== {eq, er, ez, LAT}) begin
         bad++;
         $display("FAIL after_abort got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b lat=%0d",
                  oq, orr, oz, lat, eq, er, ez, LAT);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
